// File: rtl/avalon_pio_master.sv
// Single-transfer Avalon-MM master for PIO-style slaves: command/response handshake in,
// chipselect/write_n/read_n cycles out. Optional waitrequest timeout under AVM_TIMEOUT_EN.
module avalon_pio_master #(
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DATA_W         = 18,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_address_i,
  input  logic [DATA_W-1:0] cmd_writedata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_readdata_o,
  output logic              rsp_error_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_chipselect_o,
  output logic              avm_write_n_o,
  output logic              avm_read_n_o,
  output logic [DATA_W-1:0] avm_writedata_o,
  input  logic [DATA_W-1:0] avm_readdata_i,
  input  logic              avm_waitrequest_i
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e              state_q;
  logic                dir_q;  // 1 = write
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_readdata_q;
  logic                cs_q;
  logic                write_n_q;
  logic                read_n_q;
  logic [ADDR_W-1:0]   address_q;
  logic [DATA_W-1:0]   writedata_q;

`ifdef AVM_TIMEOUT_EN
  localparam int unsigned TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TmoLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  logic [TmoW-1:0] tmo_cnt_q;
  logic            rsp_error_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      dir_q          <= 1'b0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_readdata_q <= '0;
      cs_q           <= 1'b0;
      write_n_q      <= 1'b1;
      read_n_q       <= 1'b1;
      address_q      <= '0;
      writedata_q    <= '0;
`ifdef AVM_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      rsp_error_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid_i && cmd_ready_q) begin
            state_q     <= StBus;
            dir_q       <= cmd_write_i;
            address_q   <= cmd_address_i;
            writedata_q <= cmd_writedata_i;
            cs_q        <= 1'b1;
            write_n_q   <= ~cmd_write_i;
            read_n_q    <= cmd_write_i;
            cmd_ready_q <= 1'b0;
`ifdef AVM_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
          end
        end
        StBus: begin
          if (!avm_waitrequest_i) begin
            state_q        <= StResp;
            cs_q           <= 1'b0;
            write_n_q      <= 1'b1;
            read_n_q       <= 1'b1;
            rsp_valid_q    <= 1'b1;
            rsp_readdata_q <= dir_q ? '0 : avm_readdata_i;
          end
`ifdef AVM_TIMEOUT_EN
          else if (tmo_cnt_q == TmoW'(TmoLast)) begin
            // Stalled too long: abort the cycle and report an error response.
            state_q        <= StResp;
            cs_q           <= 1'b0;
            write_n_q      <= 1'b1;
            read_n_q       <= 1'b1;
            rsp_valid_q    <= 1'b1;
            rsp_readdata_q <= '0;
            rsp_error_q    <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
`endif
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
`ifdef AVM_TIMEOUT_EN
          rsp_error_q <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_readdata_o   = rsp_readdata_q;
  assign avm_address_o    = address_q;
  assign avm_chipselect_o = cs_q;
  assign avm_write_n_o    = write_n_q;
  assign avm_read_n_o     = read_n_q;
  assign avm_writedata_o  = writedata_q;

`ifdef AVM_TIMEOUT_EN
  assign rsp_error_o = rsp_error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign rsp_error_o    = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_pio_master.sv
// Bench for avalon_pio_master: vector table, randomized transfers against a response model,
// and hand-written back-to-back, reset and (with AVM_TIMEOUT_EN) timeout sequences.
module tb_avalon_pio_master;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_writedata;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] rsp_readdata;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_write_n, avm_read_n;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic          avm_waitrequest;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  avalon_pio_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_write_i      (cmd_write),
    .cmd_address_i    (cmd_address),
    .cmd_writedata_i  (cmd_writedata),
    .rsp_valid_o      (rsp_valid),
    .rsp_readdata_o   (rsp_readdata),
    .rsp_error_o      (rsp_error),
    .avm_address_o    (avm_address),
    .avm_chipselect_o (avm_chipselect),
    .avm_write_n_o    (avm_write_n),
    .avm_read_n_o     (avm_read_n),
    .avm_writedata_o  (avm_writedata),
    .avm_readdata_i   (avm_readdata),
    .avm_waitrequest_i(avm_waitrequest)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            waits;
    logic [DW-1:0] exp_rsp;
  } vec_t;

  task automatic chk_b(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance one clock; sample on the falling edge and check the always-true strobe rules.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk_b("strobe_exclusive", !(avm_write_n === 1'b0 && avm_read_n === 1'b0), 1'b1);
    chk_b("strobe_needs_cs", (avm_write_n & avm_read_n) | avm_chipselect, 1'b1);
  endtask

  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int waits, input logic [DW-1:0] exp);
    chk_b("idle_ready", cmd_ready, 1'b1);
    cmd_valid     = 1'b1;
    cmd_write     = wr;
    cmd_address   = addr;
    cmd_writedata = wdata;
    tick();
    cmd_valid     = 1'b0;
    cmd_address   = AW'($urandom);
    cmd_writedata = DW'($urandom);
    for (int k = 0; k <= waits; k++) begin
      chk_b("bus_cs", avm_chipselect, 1'b1);
      chk_b("bus_write_n", avm_write_n, ~wr);
      chk_b("bus_read_n", avm_read_n, wr);
      chk_d("bus_address", DW'(avm_address), DW'(addr));
      chk_d("bus_writedata", avm_writedata, wdata);
      chk_b("bus_no_rsp", rsp_valid, 1'b0);
      chk_b("bus_not_ready", cmd_ready, 1'b0);
      avm_waitrequest = (k < waits);
      avm_readdata    = (k < waits) ? DW'($urandom) : rdata;
      tick();
    end
    avm_waitrequest = 1'b0;
    avm_readdata    = DW'($urandom);
    chk_b("rsp_valid", rsp_valid, 1'b1);
    chk_d("rsp_readdata", rsp_readdata, exp);
    chk_b("rsp_error", rsp_error, 1'b0);
    chk_b("rsp_cs_off", avm_chipselect, 1'b0);
    chk_b("rsp_not_ready", cmd_ready, 1'b0);
    tick();
    chk_b("post_rsp_low", rsp_valid, 1'b0);
    chk_b("post_ready", cmd_ready, 1'b1);
    chk_d("post_hold_rdata", rsp_readdata, exp);
    chk_d("idle_hold_addr", DW'(avm_address), DW'(addr));
    chk_d("idle_hold_wdata", avm_writedata, wdata);
  endtask

  initial begin
    vec_t vecs[6];
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;
    int            r_waits;

    vecs[0] = '{wr: 1'b1, addr: 2'd0, wdata: 18'h2AAAA, rdata: 18'h12345, waits: 0, exp_rsp: 18'h0};
    vecs[1] = '{wr: 1'b0, addr: 2'd0, wdata: 18'h00000, rdata: 18'h0155A, waits: 0,
                exp_rsp: 18'h0155A};
    vecs[2] = '{wr: 1'b1, addr: 2'd3, wdata: 18'h3FFFF, rdata: 18'h3FFFF, waits: 3, exp_rsp: 18'h0};
    vecs[3] = '{wr: 1'b0, addr: 2'd2, wdata: 18'h15555, rdata: 18'h3FFFF, waits: 1,
                exp_rsp: 18'h3FFFF};
    vecs[4] = '{wr: 1'b1, addr: 2'd1, wdata: 18'h00001, rdata: 18'h20000, waits: 2, exp_rsp: 18'h0};
    vecs[5] = '{wr: 1'b0, addr: 2'd3, wdata: 18'h2AAAA, rdata: 18'h00000, waits: 0, exp_rsp: 18'h0};

    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_address     = '0;
    cmd_writedata   = '0;
    avm_readdata    = '0;
    avm_waitrequest = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_b("rst_cmd_ready", cmd_ready, 1'b1);
    chk_b("rst_rsp_valid", rsp_valid, 1'b0);
    chk_d("rst_rsp_readdata", rsp_readdata, '0);
    chk_b("rst_rsp_error", rsp_error, 1'b0);
    chk_b("rst_cs", avm_chipselect, 1'b0);
    chk_b("rst_write_n", avm_write_n, 1'b1);
    chk_b("rst_read_n", avm_read_n, 1'b1);
    chk_d("rst_address", DW'(avm_address), '0);
    chk_d("rst_writedata", avm_writedata, '0);

    foreach (vecs[i])
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].waits,
             vecs[i].exp_rsp);

    // Back-to-back: cmd_valid stays high, second command waits for cmd_ready.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd2; cmd_writedata = 18'h0F0F0;
    tick();
    cmd_write = 1'b0; cmd_address = 2'd3; avm_readdata = 18'h2C3C3;
    chk_b("b2b_a_write_n", avm_write_n, 1'b0);
    chk_d("b2b_a_addr", DW'(avm_address), DW'(2'd2));
    chk_b("b2b_a_not_ready", cmd_ready, 1'b0);
    tick();
    chk_b("b2b_a_rsp", rsp_valid, 1'b1);
    chk_d("b2b_a_rdata", rsp_readdata, '0);
    chk_b("b2b_a_resp_cs", avm_chipselect, 1'b0);
    tick();
    chk_b("b2b_ready_back", cmd_ready, 1'b1);
    chk_b("b2b_idle_cs", avm_chipselect, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk_b("b2b_b_cs", avm_chipselect, 1'b1);
    chk_b("b2b_b_read_n", avm_read_n, 1'b0);
    chk_d("b2b_b_addr", DW'(avm_address), DW'(2'd3));
    tick();
    chk_b("b2b_b_rsp", rsp_valid, 1'b1);
    chk_d("b2b_b_rdata", rsp_readdata, 18'h2C3C3);
    tick();
    chk_b("b2b_b_ready", cmd_ready, 1'b1);

    // Randomized transfers: a read returns the slave's data, a write returns zero.
    for (int n = 0; n < 40; n++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = AW'($urandom);
      r_wdata = DW'($urandom);
      r_rdata = DW'($urandom);
      r_waits = $urandom_range(0, 3);
      do_txn(r_wr, r_addr, r_wdata, r_rdata, r_waits, r_wr ? '0 : r_rdata);
    end

    // Reset during a waitrequest stall.
    do_txn(1'b0, 2'd1, 18'h0, 18'h1ABCD, 0, 18'h1ABCD);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd2; cmd_writedata = 18'h3FFFF;
    avm_waitrequest = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk_b("stall_cs", avm_chipselect, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_b("midrst_cs", avm_chipselect, 1'b0);
    chk_b("midrst_write_n", avm_write_n, 1'b1);
    chk_b("midrst_read_n", avm_read_n, 1'b1);
    chk_b("midrst_ready", cmd_ready, 1'b1);
    chk_b("midrst_rsp", rsp_valid, 1'b0);
    chk_d("midrst_rdata", rsp_readdata, '0);
    avm_waitrequest = 1'b0;
    tick();
    chk_b("midrst_no_rsp1", rsp_valid, 1'b0);
    tick();
    chk_b("midrst_no_rsp2", rsp_valid, 1'b0);

    // Reset wins over a simultaneous command.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd3; cmd_writedata = 18'h11111;
    tick();
    reset = 1'b1;
    tick();
    cmd_valid = 1'b0;
    reset = 1'b0;
    tick();
    cmd_valid = 1'b1;
    reset = 1'b1;
    tick();
    cmd_valid = 1'b0;
    reset = 1'b0;
    chk_b("rstcmd_cs", avm_chipselect, 1'b0);
    chk_b("rstcmd_ready", cmd_ready, 1'b1);
    chk_d("rstcmd_addr", DW'(avm_address), '0);
    tick();
    chk_b("rstcmd_no_bus", avm_chipselect, 1'b0);
    chk_b("rstcmd_no_rsp", rsp_valid, 1'b0);

`ifdef AVM_TIMEOUT_EN
    // Waitrequest stuck high: abort after four BUS cycles with an error response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd1;
    avm_readdata = 18'h3AAAA;
    tick();
    cmd_valid = 1'b0;
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_b("tmo_bus_cs", avm_chipselect, 1'b1);
      chk_b("tmo_bus_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    chk_b("tmo_rsp", rsp_valid, 1'b1);
    chk_b("tmo_err", rsp_error, 1'b1);
    chk_d("tmo_rdata", rsp_readdata, '0);
    chk_b("tmo_cs_off", avm_chipselect, 1'b0);
    avm_waitrequest = 1'b0;
    tick();
    chk_b("tmo_rsp_low", rsp_valid, 1'b0);
    chk_b("tmo_err_low", rsp_error, 1'b0);
    chk_b("tmo_ready", cmd_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
